sm4_key_schedule: RTL
=====================

# sm4_key_schedule

Sequential SM4 key-expansion engine that turns a 128-bit master key into the 32 round keys rk0..rk31 and holds them in an internal round-key file for the cipher datapath. It runs a configurable number of key-expansion rounds per clock (UNROLL) and generates CK constants internally. Round keys can be read in encryption order or in reversed (decryption) order. It sits between the key-load interface and the encrypt/decrypt round core.

## Interface
- UNROLL, default 1: key-expansion rounds per clock; legal values 1, 2, 4, 8 (divides 32).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  128  master key MK0..MK3, MK0 in bits [127:96].
- key_valid  in  1  master key offered.
- key_ready  out  1  engine can accept a key; high in IDLE and READY.
- busy  out  1  expansion in progress (EXPAND).
- done  out  1  one-cycle pulse when all 32 round keys are written.
- keys_valid  out  1  round-key file holds a complete schedule for the last accepted key.
- rk_rd_en  in  1  round-key read request.
- rk_rd_idx  in  5  logical round index 0..31.
- rk_rd_decrypt  in  1  0: physical index = idx; 1: physical index = 31 - idx.
- rk_rd_data  out  32  registered round key.
- rk_rd_valid  out  1  rk_rd_data valid this cycle.

## Operation
- FK = a3b1bac6, 56aa3350, 677d9197, b27022dc. On accept, K0..K3 = MK0..MK3 ^ FK0..FK3 is loaded into a 128-bit state register.
- CKi is computed combinationally: byte j (j=0 MSB) = (4i+j)*7 mod 256, 8-bit wrap. CK0 = 00070e15, CK1 = 1c232a31, CK31 = 646b7279.
- Round i: rk_i = K_i ^ T'(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i). T' is the existing transform_for_key_exp, which applies the S-box τ and then L'(B) = B ^ (B<<<13) ^ (B<<<23). State shifts to {K_{i+1}, K_{i+2}, K_{i+3}, rk_i}.
- UNROLL copies are chained in one cycle. Copy u handles round cnt+u and writes rk file entry cnt+u.
- Round counter cnt is 5 bits and steps by UNROLL. The last step wraps to 0 and is used as the terminal condition.
- FSM states:
  - IDLE: key_ready=1. On key_valid: load state, cnt=0, go to EXPAND.
  - EXPAND: busy=1, key_ready=0, keys_valid=0. Runs 32/UNROLL cycles, then goes to READY with done=1 for one cycle.
  - READY: key_ready=1, keys_valid=1. On key_valid: load the new key, keys_valid drops to 0 on the same edge, go to EXPAND.
- key_valid while key_ready=0 is ignored; key_in is not sampled.
- Reads: rk_rd_en sampled at an edge gives rk_rd_data and rk_rd_valid=1 on the next cycle.
  - rk_rd_valid = rk_rd_en & keys_valid, registered.
  - When the read is not valid, rk_rd_data holds its previous value.
- Reset: every output and the state register go to 0; FSM to IDLE, cnt=0.
  - After reset, key_ready is 1 from the first cycle following the reset edge.
  - The round-key file is not cleared; keys_valid=0 gates all reads.
- Reset in mid-EXPAND aborts expansion. No done pulse; keys_valid stays 0.
- Simultaneous rk_rd_en and key accept in READY: the read returns the old schedule with rk_rd_valid=1. The file is first overwritten on the following edge.

## Timing
- Accept edge t: state loaded, FSM to EXPAND.
- Edges t+1 .. t+32/UNROLL: each writes UNROLL round keys.
- done and keys_valid are first high in the cycle after edge t+32/UNROLL. Key-to-ready latency is 32/UNROLL+1 edges: 33 for UNROLL=1, 5 for UNROLL=8.
- done is high exactly one cycle per completed schedule.
- Read latency is 1 cycle, fully pipelined: one read per cycle.
- Critical path is UNROLL chained T' stages plus CK generation; UNROLL=8 is for low-frequency targets only.

## Test plan
- MK = 0123456789abcdeffedcba9876543210, UNROLL=1:
  - done pulses exactly 33 cycles after the accept edge.
  - Encrypt-order reads give idx0 = f12186f9, idx1 = 41662b61, idx31 = 9124a012.
- Same key, UNROLL=2/4/8: identical rk0..rk31 to UNROLL=1. done arrives 17/9/5 cycles after accept.
- Decrypt-order read with rk_rd_decrypt=1: idx0 = 9124a012, idx31 = f12186f9.
- rst asserted on the 10th EXPAND cycle:
  - Next cycle: key_ready=1, keys_valid=0, busy=0, no done.
  - Reads give rk_rd_valid=0.
  - Re-keying afterwards gives the correct schedule.
- In READY, new key 0 offered together with a read of idx0:
  - rk_rd_data = f12186f9, rk_rd_valid=1.
  - keys_valid=0 for the next 32/UNROLL cycles, then the new schedule.
- key_valid pulsed during EXPAND: ignored; the schedule matches the original key.

Source files
------------

// File: rtl/sm4_key_schedule.sv
// SM4 key-expansion engine: expands a 128-bit master key into the 32 round
// keys rk0..rk31, UNROLL rounds per clock, into a round-key file that is
// read back one word per cycle in encryption or decryption order.
module sm4_key_schedule #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic         rk_rd_en,
    input  logic [4:0]   rk_rd_idx,
    input  logic         rk_rd_decrypt,
    output logic [31:0]  rk_rd_data,
    output logic         rk_rd_valid
);

    localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;

    // SM4 S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_READY
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           load;
    logic           step;
    logic           last;
    logic [4:0]     cnt;
    logic [127:0]   kstate;
    logic [31:0]    rk_file [32];
    logic [127:0]   chain [UNROLL+1];
    logic [31:0]    rk_new [UNROLL];
    logic [4:0]     rd_phys;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    // CK_i byte j = (4i + j) * 7 mod 256, byte 0 is the most significant.
    function automatic logic [31:0] ck_gen(input logic [4:0] i);
        logic [31:0] ck;
        ck = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            ck[31 - 8*j -: 8] = 8'(({1'b0, i, 2'b00} + 8'(j)) * 8'd7);
        end
        return ck;
    endfunction

    // T': byte-wise S-box followed by L'(B) = B ^ (B <<< 13) ^ (B <<< 23).
    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        for (int unsigned j = 0; j < 4; j++) begin
            b[31 - 8*j -: 8] = sbox(a[31 - 8*j -: 8]);
        end
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    assign last       = (cnt + 5'(UNROLL)) == 5'd0;
    assign key_ready  = (state_q != S_EXPAND);
    assign busy       = (state_q == S_EXPAND);
    assign keys_valid = (state_q == S_READY);
    assign rd_phys    = rk_rd_decrypt ? (5'd31 - rk_rd_idx) : rk_rd_idx;

    // UNROLL chained key-expansion rounds starting at round cnt.
    always_comb begin
        chain[0] = kstate;
        for (int unsigned u = 0; u < UNROLL; u++) begin
            rk_new[u] = chain[u][127:96] ^
                        t_key(chain[u][95:64] ^ chain[u][63:32] ^ chain[u][31:0] ^
                              ck_gen(cnt + 5'(u)));
            chain[u+1] = {chain[u][95:0], rk_new[u]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and load/step strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE, S_READY: begin
                if (key_valid) begin
                    load    = 1'b1;
                    state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                step = 1'b1;
                if (last) state_d = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Key state, round counter and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            kstate <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= step & last;
            if (load) begin
                kstate <= key_in ^ FK;
                cnt    <= '0;
            end else if (step) begin
                kstate <= chain[UNROLL];
                cnt    <= cnt + 5'(UNROLL);
            end
        end
    end

    // Round-key file writes; contents survive reset, keys_valid gates reads.
    always_ff @(posedge clk) begin
        if (!rst && step) begin
            for (int unsigned u = 0; u < UNROLL; u++) begin
                rk_file[cnt + 5'(u)] <= rk_new[u];
            end
        end
    end

    // Registered read port; data holds when no valid read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_rd_data  <= '0;
            rk_rd_valid <= 1'b0;
        end else begin
            rk_rd_valid <= rk_rd_en & keys_valid;
            if (rk_rd_en && keys_valid) rk_rd_data <= rk_file[rd_phys];
        end
    end

endmodule
